branch_update_queue: RTL and testbench
======================================

// Module: branch_update_queue
// PURPOSE
//  Sits between fetch-side branch prediction and execute-side branch resolution. Records every predicted
//  conditional branch in order and, when execute resolves the oldest one, generates the training update.
//  That update is the PHT index plus per-predictor correctness, used by predictor 1, predictor 2 and the
//  2-bit chooser table. On a mispredict it raises a one-cycle flush and squashes all younger entries.
// PARAMETERS
//  DEPTH   4   in-flight branch entries; power of two, >=2
//  IDX_W   10  predictor/chooser table index width
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      asynchronous, active-high reset
//  push_valid     in   1      fetch predicted a conditional branch this cycle
//  push_ready     out  1      queue can accept a push (not full)
//  push_idx       in   IDX_W  table index used for the prediction
//  push_pred1     in   1      predictor 1 direction (1 = taken)
//  push_pred2     in   1      predictor 2 direction
//  push_sel       in   1      chooser output (1 = predictor 2 used)
//  res_valid      in   1      execute resolved the oldest in-flight branch
//  res_taken      in   1      actual direction
//  upd_valid      out  1      one-cycle training pulse
//  upd_idx        out  IDX_W  index to train
//  upd_taken      out  1      actual direction (for both PHTs)
//  upd_ok1        out  1      predictor 1 was correct
//  upd_ok2        out  1      predictor 2 was correct
//  flush          out  1      one-cycle mispredict pulse to the front end
//  count          out  $clog2(DEPTH)+1  occupancy
//  err_underflow  out  1      sticky: res_valid seen while empty
// BEHAVIOUR
//  - Circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits wrapping mod DEPTH, plus a count register.
//    push_ready = (count != DEPTH). Combinational from count only.
//  - A push is accepted when push_valid && push_ready. A push while full is ignored; the queue is unchanged.
//  - Resolve pops the head entry. Final prediction = push_sel ? pred2 : pred1 of that entry.
//  - Outputs are registered, 1-cycle latency: in the cycle after resolve,
//    upd_valid=1, upd_idx=entry idx, upd_taken=res_taken,
//    upd_ok1=(pred1==res_taken), upd_ok2=(pred2==res_taken), flush=(final!=res_taken).
//    Otherwise upd_valid=0 and flush=0; upd_idx/upd_ok* hold their last values.
//  - Mispredict: at the resolving edge all remaining entries are discarded (count<=0, wr_ptr<=rd_ptr+1).
//    A push in that same cycle is dropped, because it is on the wrong path.
//  - Simultaneous push and correct-resolve while full: the pop frees a slot but push_ready is still 0,
//    so the push is not accepted. Push and correct-resolve with 0<count<DEPTH: count is unchanged.
//  - Resolve while empty: no pop, no upd_valid, err_underflow<=1 (cleared only by rst).
//  - Reset (asynchronous, any time including mid-operation): pointers=0, count=0, upd_valid=0, flush=0,
//    upd_idx=0, upd_taken=0, upd_ok1=0, upd_ok2=0, err_underflow=0, so push_ready=1. Entry storage
//    need not be reset.
//  - Agreement case (ok1==ok2): consumers leave the chooser unchanged; this block still issues upd_valid
//    so both PHTs train.
// TESTING
//  1 Reset: assert rst mid-stream with count=3 -> count=0, push_ready=1, upd_valid=0, flush=0 immediately.
//  2 In-order: push idx 0x005,0x006 (pred1=1,pred2=0,sel=0); resolve taken twice -> two upd_valid pulses:
//    idx 0x005 then 0x006, ok1=1, ok2=0, flush=0.
//  3 Full: push DEPTH=4 entries -> push_ready=0; a 5th push is ignored; then resolve+push in the same
//    cycle -> count=3, the push is not taken.
//  4 Mispredict: entries idx 0x010(sel=1,pred2=1),0x011,0x012; resolve not-taken -> next cycle flush=1,
//    upd_idx=0x010, ok2=0, count=0; a push in the resolve cycle is dropped.
//  5 Wrap: 10 push/resolve pairs with DEPTH=4 -> upd_idx sequence matches push order across pointer wrap.
//  6 Underflow: res_valid with count=0 -> err_underflow=1 stays high, upd_valid=0, count stays 0.

Source files
------------

// File: rtl/branch_update_queue_if.sv
// Handshake bundle between branch prediction/resolution and the update queue.
// master: fetch/execute side driving pushes and resolves; slave: the queue itself.
interface branch_update_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 10
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             push_valid;
  logic             push_ready;
  logic [IDX_W-1:0] push_idx;
  logic             push_pred1;
  logic             push_pred2;
  logic             push_sel;
  logic             res_valid;
  logic             res_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ok1;
  logic             upd_ok2;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             err_underflow;

  modport master (
    output push_valid, push_idx, push_pred1, push_pred2, push_sel, res_valid, res_taken,
    input  push_ready, upd_valid, upd_idx, upd_taken, upd_ok1, upd_ok2, flush, count,
           err_underflow
  );

  modport slave (
    input  push_valid, push_idx, push_pred1, push_pred2, push_sel, res_valid, res_taken,
    output push_ready, upd_valid, upd_idx, upd_taken, upd_ok1, upd_ok2, flush, count,
           err_underflow
  );
endinterface

// File: rtl/branch_update_queue.sv
// In-order queue of predicted conditional branches. Resolving the oldest entry produces a
// registered training update for both PHTs and the chooser, and a flush pulse on mispredict
// that squashes every younger (wrong-path) entry.
module branch_update_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 10
) (
  input logic                  clk,
  input logic                  rst,
  branch_update_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Entry storage; contents are qualified by count, so no reset is needed.
  logic [IDX_W-1:0] idx_mem   [DEPTH];
  logic             pred1_mem [DEPTH];
  logic             pred2_mem [DEPTH];
  logic             sel_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             upd_valid_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_taken_q;
  logic             upd_ok1_q;
  logic             upd_ok2_q;
  logic             flush_q;
  logic             err_underflow_q;

  logic             push_ready;
  logic             empty;
  logic             do_res;
  logic             do_push;
  logic             final_pred;
  logic             mispredict;
  logic             head_pred1;
  logic             head_pred2;
  logic             head_sel;
  logic [IDX_W-1:0] head_idx;

  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign empty      = (count_q == '0);

  // Decode resolve/push and compute next pointer and occupancy state.
  always_comb begin
    head_idx   = idx_mem[rd_ptr_q];
    head_pred1 = pred1_mem[rd_ptr_q];
    head_pred2 = pred2_mem[rd_ptr_q];
    head_sel   = sel_mem[rd_ptr_q];
    final_pred = head_sel ? head_pred2 : head_pred1;
    do_res     = bus.res_valid && !empty;
    mispredict = do_res && (final_pred != bus.res_taken);
    // A push racing a mispredict is on the wrong path and is dropped.
    do_push    = bus.push_valid && push_ready && !mispredict;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (do_res) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (mispredict) begin
      wr_ptr_d = rd_ptr_q + 1'b1;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_res};
    end
  end

  // Pointer, occupancy and registered update/flush outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      upd_valid_q     <= 1'b0;
      upd_idx_q       <= '0;
      upd_taken_q     <= 1'b0;
      upd_ok1_q       <= 1'b0;
      upd_ok2_q       <= 1'b0;
      flush_q         <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      upd_valid_q <= do_res;
      flush_q     <= mispredict;
      // Index and correctness hold between updates.
      if (do_res) begin
        upd_idx_q   <= head_idx;
        upd_taken_q <= bus.res_taken;
        upd_ok1_q   <= (head_pred1 == bus.res_taken);
        upd_ok2_q   <= (head_pred2 == bus.res_taken);
      end
      if (bus.res_valid && empty) begin
        err_underflow_q <= 1'b1;
      end
    end
  end

  // Write the accepted prediction into the tail slot.
  always_ff @(posedge clk) begin
    if (do_push) begin
      idx_mem[wr_ptr_q]   <= bus.push_idx;
      pred1_mem[wr_ptr_q] <= bus.push_pred1;
      pred2_mem[wr_ptr_q] <= bus.push_pred2;
      sel_mem[wr_ptr_q]   <= bus.push_sel;
    end
  end

  assign bus.push_ready    = push_ready;
  assign bus.upd_valid     = upd_valid_q;
  assign bus.upd_idx       = upd_idx_q;
  assign bus.upd_taken     = upd_taken_q;
  assign bus.upd_ok1       = upd_ok1_q;
  assign bus.upd_ok2       = upd_ok2_q;
  assign bus.flush         = flush_q;
  assign bus.count         = count_q;
  assign bus.err_underflow = err_underflow_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: stimulus pushes expected updates into a
// scoreboard, a negedge monitor pops and compares every update pulse.
module tb_branch_update_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 10;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic             ok1;
    logic             ok2;
    logic             flush;
  } upd_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  upd_t sb[$];

  branch_update_queue_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

  branch_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_upd(input logic [IDX_W-1:0] idx, input logic taken, input logic ok1,
                            input logic ok2, input logic fl);
    upd_t e;
    e.idx = idx; e.taken = taken; e.ok1 = ok1; e.ok2 = ok2; e.flush = fl;
    sb.push_back(e);
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic drive(input logic pv, input logic [IDX_W-1:0] idx, input logic p1,
                       input logic p2, input logic sel, input logic rv, input logic rt);
    bus.push_valid = pv;
    bus.push_idx   = idx;
    bus.push_pred1 = p1;
    bus.push_pred2 = p2;
    bus.push_sel   = sel;
    bus.res_valid  = rv;
    bus.res_taken  = rt;
    @(posedge clk);
    #1;
    bus.push_valid = 1'b0;
    bus.res_valid  = 1'b0;
  endtask

  task automatic push(input logic [IDX_W-1:0] idx, input logic p1, input logic p2,
                      input logic sel);
    drive(1'b1, idx, p1, p2, sel, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic rt);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, rt);
  endtask

  // Monitor: compare each update pulse against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.upd_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_upd_valid", 32'(bus.upd_valid), 32'd0);
        end else begin
          upd_t e;
          e = sb.pop_front();
          chk("upd_idx",   32'(bus.upd_idx),   32'(e.idx));
          chk("upd_taken", 32'(bus.upd_taken), 32'(e.taken));
          chk("upd_ok1",   32'(bus.upd_ok1),   32'(e.ok1));
          chk("upd_ok2",   32'(bus.upd_ok2),   32'(e.ok2));
          chk("flush",     32'(bus.flush),     32'(e.flush));
        end
      end else begin
        chk("flush_without_upd", 32'(bus.flush), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.push_valid = 1'b0;
    bus.push_idx   = '0;
    bus.push_pred1 = 1'b0;
    bus.push_pred2 = 1'b0;
    bus.push_sel   = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_taken  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",      32'(bus.count),         32'd0);
    chk("rst_push_ready", 32'(bus.push_ready),    32'd1);
    chk("rst_upd_idx",    32'(bus.upd_idx),       32'd0);
    chk("rst_ok1",        32'(bus.upd_ok1),       32'd0);
    chk("rst_err",        32'(bus.err_underflow), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: asynchronous reset mid-stream, count=3 with an update pulse in flight.
    push(10'h001, 1'b1, 1'b1, 1'b0);
    push(10'h002, 1'b1, 1'b1, 1'b0);
    push(10'h003, 1'b1, 1'b1, 1'b0);
    push(10'h004, 1'b1, 1'b1, 1'b0);
    resolve(1'b1);  // pulse is cleared by reset before the monitor samples
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("arst_count",      32'(bus.count),      32'd0);
    chk("arst_push_ready", 32'(bus.push_ready), 32'd1);
    chk("arst_upd_valid",  32'(bus.upd_valid),  32'd0);
    chk("arst_flush",      32'(bus.flush),      32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // 2: in-order resolution, predictor 1 right and predictor 2 wrong.
    push(10'h005, 1'b1, 1'b0, 1'b0);
    push(10'h006, 1'b1, 1'b0, 1'b0);
    expect_upd(10'h005, 1'b1, 1'b1, 1'b0, 1'b0);
    resolve(1'b1);
    expect_upd(10'h006, 1'b1, 1'b1, 1'b0, 1'b0);
    resolve(1'b1);
    chk("inorder_count", 32'(bus.count), 32'd0);

    // 3: full queue, ignored push, and resolve+push while full.
    for (int i = 0; i < 4; i++) push(10'h020 + 10'(i), 1'b1, 1'b1, 1'b0);
    chk("full_ready", 32'(bus.push_ready), 32'd0);
    chk("full_count", 32'(bus.count),      32'd4);
    push(10'h0FF, 1'b0, 1'b0, 1'b0);
    chk("full_ignored_count", 32'(bus.count), 32'd4);
    expect_upd(10'h020, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 10'h0EE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("full_res_push_count", 32'(bus.count),      32'd3);
    chk("full_res_push_ready", 32'(bus.push_ready), 32'd1);
    expect_upd(10'h021, 1'b1, 1'b1, 1'b1, 1'b0);
    resolve(1'b1);
    expect_upd(10'h022, 1'b1, 1'b1, 1'b1, 1'b0);
    resolve(1'b1);
    expect_upd(10'h023, 1'b1, 1'b1, 1'b1, 1'b0);
    resolve(1'b1);
    chk("full_drain_count", 32'(bus.count), 32'd0);

    // 4: mispredict squashes younger entries and the concurrent push.
    push(10'h010, 1'b1, 1'b1, 1'b1);
    push(10'h011, 1'b0, 1'b0, 1'b0);
    push(10'h012, 1'b0, 1'b0, 1'b0);
    expect_upd(10'h010, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 10'h013, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mispred_count", 32'(bus.count),      32'd0);
    chk("mispred_ready", 32'(bus.push_ready), 32'd1);
    push(10'h030, 1'b0, 1'b1, 1'b1);
    chk("post_flush_count", 32'(bus.count), 32'd1);
    expect_upd(10'h030, 1'b1, 1'b0, 1'b1, 1'b0);
    resolve(1'b1);
    @(posedge clk);
    #1;
    chk("hold_upd_idx", 32'(bus.upd_idx), 32'h030);
    chk("hold_upd_ok2", 32'(bus.upd_ok2), 32'd1);

    // 5: ten back-to-back push/resolve pairs across pointer wrap.
    push(10'h100, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < 10; i++) begin
      logic odd;
      odd = (i % 2) == 1;
      expect_upd(10'h100 + 10'(i - 1), 1'b1, !odd, odd, 1'b0);
      drive(1'b1, 10'h100 + 10'(i), odd, !odd, !odd, 1'b1, 1'b1);
    end
    expect_upd(10'h109, 1'b1, 1'b1, 1'b0, 1'b0);
    resolve(1'b1);
    chk("wrap_count", 32'(bus.count), 32'd0);

    // 6: resolve while empty sets the sticky error without an update.
    resolve(1'b1);
    chk("underflow_err",   32'(bus.err_underflow), 32'd1);
    chk("underflow_count", 32'(bus.count),         32'd0);
    @(negedge clk);
    chk("underflow_no_upd", 32'(bus.upd_valid), 32'd0);
    @(posedge clk);
    #1;
    push(10'h040, 1'b1, 1'b0, 1'b0);
    expect_upd(10'h040, 1'b1, 1'b1, 1'b0, 1'b0);
    resolve(1'b1);
    chk("underflow_sticky", 32'(bus.err_underflow), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
